sprite_dma_ctrl: RTL
====================

Name: sprite_dma_ctrl

Overview:
- Sequences the sprite DMA that the CPU triggers through the sprite_dma strobe from the address decoder (M72: I/O port 0x04; M84: memory write to 0xbc000).
- Copies the CPU-visible object RAM (the sprite_memrq region) into the sprite engine's private object buffer, one word per cycle.
- Sits between the address decoder, the object RAM second read port and the sprite renderer's buffer write port.
- Optionally defers the copy to vertical blank and queues one re-trigger that arrives mid-copy.

Parameters:
- WORDS, 512, number of 16-bit words copied per DMA; must be a power of two, at least 2.
- AW, 9, address width; log2(WORDS).
- VBL_SYNC, 1, 1 = start copy only while vblank=1; 0 = start on the cycle after the trigger.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dma_trig  in  1  sprite_dma from the address decoder; a level held for the whole CPU write cycle
- vblank  in  1  vertical blank, synchronous to clk
- src_addr  out  AW  object RAM read address; read latency is exactly 1 cycle
- src_data  in  16  object RAM read data
- dst_addr  out  AW  object buffer write address
- dst_data  out  16  object buffer write data
- dst_we  out  1  object buffer write enable
- busy  out  1  high from acceptance of a trigger until the copy completes
- done  out  1  one-cycle pulse after the last word is written

Behaviour:
- Reset (async assert, sync release): state IDLE, pending=0, src_addr=0, dst_addr=0, dst_data=0, dst_we=0, busy=0, done=0, internal trigger-edge register=0.
- Trigger detect:
  - Rising edge of dma_trig only (registered previous value). Holding the level never re-triggers.
  - An edge sets pending.
- States:
  - IDLE: if pending and (VBL_SYNC=0 or vblank=1), clear pending, set src_addr=0, go to READ. If pending and VBL_SYNC=1 with vblank=0, go to WAIT_VBL. busy=1 whenever pending=1 or state!=IDLE.
  - WAIT_VBL: stay until vblank=1; then clear pending, set src_addr=0, go to READ.
  - READ: first read issued (src_addr=0); increment src_addr; go to COPY.
  - COPY: each cycle, dst_we=1, dst_addr = previous src_addr, dst_data = src_data; src_addr increments. When dst_addr = WORDS-1 has been written, go to DONE.
  - DONE: done=1 for one cycle, dst_we=0; go to IDLE.
- Latency:
  - VBL_SYNC=0: trigger edge at cycle T gives the first dst_we at T+3.
  - The last write is at T+2+WORDS; done is at T+3+WORDS.
  - Exactly WORDS writes, addresses 0..WORDS-1 ascending, no gaps, no duplicates.
- Address wrap: src_addr wraps to 0 after WORDS-1 (AW bits). The read issued during the final COPY cycle is discarded.
- Trigger during copy:
  - The edge sets pending; the current copy is not restarted or truncated.
  - On return to IDLE a second full copy runs, subject to vblank as above.
  - Multiple edges during one copy collapse into a single pending.
- vblank falling mid-copy: the copy continues to completion. vblank only gates the start.
- Trigger and DONE on the same cycle: pending is set. Not lost.
- dst_we is 0 in every state except COPY.
- dst_addr and dst_data hold their last values when idle.
- Reset mid-copy: immediate return to reset values. pending is cleared and the partial copy is abandoned.

Test Plan:
- VBL_SYNC=0, WORDS=512. dma_trig high for 4 cycles from cycle 10 -> first dst_we at cycle 13 with dst_addr=0. 512 consecutive writes with dst_data == RAM[dst_addr]. done pulses once at cycle 525. Only one copy occurs.
- VBL_SYNC=1, vblank=0. Trigger at cycle 10, vblank rises at cycle 200 -> busy=1 from cycle 11. No dst_we before cycle 200. First write (addr 0) at 202. done at 714.
- Second trigger edge at write index 100 of a running copy -> the first copy completes all 512 words. A second copy of 512 words starts after the done pulse; exactly two done pulses in total.
- Three trigger edges during one copy -> exactly two copies and two done pulses.
- vblank drops at write index 50 (VBL_SYNC=1) -> writes 51..511 still occur contiguously. done pulses once.
- reset_n low at write index 300 -> dst_we, busy and done are 0 asynchronously. After release with no trigger, no writes occur for 1000 cycles. A new trigger then gives a full copy starting at addr 0.

Source files
------------

// File: rtl/sprite_dma_ctrl.sv
// Sprite DMA sequencer: copies the CPU-visible object RAM into the sprite engine's
// private object buffer, one word per cycle, optionally deferred to vertical blank.
module sprite_dma_ctrl #(
  parameter int WORDS    = 512,
  parameter int AW       = 9,
  parameter int VBL_SYNC = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dma_trig,
  input  logic          vblank,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_data,
  output logic [AW-1:0] dst_addr,
  output logic [15:0]   dst_data,
  output logic          dst_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VBL,
    S_READ,
    S_COPY,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic          trig_q;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic [AW-1:0] dst_addr_q, dst_addr_d;
  logic [15:0]   dst_data_q, dst_data_d;
  logic          vbl_ok;

  assign vbl_ok = (VBL_SYNC == 0) || vblank;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | (dma_trig & ~trig_q);
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    dst_we     = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          if (vbl_ok) begin
            state_d    = S_READ;
            pending_d  = 1'b0;
            src_addr_d = '0;
          end else begin
            state_d = S_WAIT_VBL;
          end
        end
      end
      S_WAIT_VBL: begin
        if (vblank) begin
          state_d    = S_READ;
          pending_d  = 1'b0;
          src_addr_d = '0;
        end
      end
      S_READ: begin
        src_addr_d = src_addr_q + 1'b1;
        dst_addr_d = src_addr_q;
        state_d    = S_COPY;
      end
      S_COPY: begin
        dst_we     = 1'b1;
        dst_data_d = src_data;
        src_addr_d = src_addr_q + 1'b1;
        // Address freezes on the last word so it holds WORDS-1 while idle.
        if (dst_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          dst_addr_d = src_addr_q;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is async assert.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      trig_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      trig_q     <= dma_trig;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
    end
  end

  // RAM data arrives one cycle after the address, so the write data bypasses the register.
  assign dst_data = (state_q == S_COPY) ? src_data : dst_data_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign busy     = pending_q || (state_q != S_IDLE);

endmodule
